// File: rtl/div_seq_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU.
// Holds the pipeline via stall_req while busy and delivers quotient/remainder
// for the HI/LO write with a one-cycle done pulse.
module div_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StFix,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    // Captured operands; dvs_q is replaced by |divisor| in PREP.
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    // Partial remainder and quotient shift register.
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    // Architecturally visible results, held until the next FIX / div-by-zero.
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    // One restoring step: shifted remainder and trial subtraction at WIDTH+1 bits.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic               dvs_zero;
    logic               last_iter;

    // Magnitude of a value when interpreted as signed (only if en is set).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction

    // Datapath helpers for the iteration step and PREP/ITER decisions.
    always_comb begin
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_sh - {1'b0, dvs_q};
        dvs_zero  = (dvs_q == '0);
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle: begin
                // A start accompanied by a flush is dropped.
                if (start && !cancel) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = signed_div;
                    state_d = StPrep;
                end
            end

            StPrep: begin
                if (cancel) begin
                    state_d = StIdle;
                end else if (dvs_zero) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                    state_d     = StDone;
                end else begin
                    quo_d   = abs_val(dvd_q, sgn_q);
                    dvs_d   = abs_val(dvs_q, sgn_q);
                    rem_d   = '0;
                    q_neg_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg_d = sgn_q & dvd_q[WIDTH-1];
                    cnt_d   = '0;
                    state_d = StIter;
                end
            end

            StIter: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    // Non-negative trial means the divisor fits: keep it, emit a 1.
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = StFix;
                    end
                end
            end

            StFix: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    quotient_d  = q_neg_q ? -quo_q : quo_q;
                    remainder_d = r_neg_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                    state_d     = StDone;
                end
            end

            StDone: begin
                // Flush has no effect here; the result is already committed.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Status outputs decoded from the state; stall_req also covers the accept cycle.
    always_comb begin
        busy        = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
        done        = (state_q == StDone);
        stall_req   = (start && (state_q == StIdle) && !cancel) || busy;
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the 32-bit integer divide operations (DIV/DIVU) that the single-cycle ALU cannot complete.
- Accepts a start pulse from the execute stage and runs a radix-2 restoring division over a private 33-bit subtractor.
- Raises a stall request to hold the pipeline while busy, and delivers quotient/remainder for the HI/LO write.
- Sits beside the ALU in the execute stage; the main decoder's aluop path selects it.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request a divide; sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  WIDTH  numerator; captured on start.
- divisor  in  WIDTH  denominator; captured on start.
- cancel  in  1  pipeline flush; aborts the operation in progress.
- busy  out  1  operation in progress (PREP, ITER, FIX).
- stall_req  out  1  combinational: (start & state==IDLE & ~cancel) | busy.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  result quotient (to LO).
- remainder  out  WIDTH  result remainder (to HI).
- div_by_zero  out  1  set with done when the captured divisor was 0.

Behaviour:
- Reset: async on rst_n low. State goes to IDLE; counter, internal registers, busy, done, quotient, remainder and div_by_zero all go to 0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE -> PREP: on start=1 & cancel=0. Captures operands and signed_div.
- start is ignored in all non-IDLE states. start with cancel in the same cycle is ignored.
- PREP (1 cycle):
  - If divisor==0, go to DONE with quotient=all ones, remainder=captured dividend, div_by_zero=1.
  - Otherwise take absolute values when signed. Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend). Clear counter; go to ITER.
- ITER (exactly WIDTH cycles): per cycle, shift {rem,quo} left 1, trial = rem - |divisor| at 33 bits. If trial is non-negative, rem = trial and quo LSB = 1; else quo LSB = 0. Counter increments; when it reaches WIDTH-1 this cycle, go to FIX.
- FIX (1 cycle): negate quo if q_neg; negate rem if r_neg; load quotient/remainder; clear div_by_zero; go to DONE.
- DONE (1 cycle): done=1, busy=0, stall_req=0; go to IDLE. A start in this cycle is not accepted; it is sampled in the following IDLE cycle.
- Latency with divisor!=0: done is high in cycle N+35, where N is the cycle start was sampled. With divisor==0: cycle N+2.
- Output hold: quotient, remainder and div_by_zero hold their values until the next FIX or divide-by-zero PREP. done is never high outside DONE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps), remainder 0, div_by_zero=0.
- Cancel in PREP/ITER/FIX: the next state is IDLE. No done pulse; outputs keep their prior values; busy falls the next cycle.
- Cancel in DONE: no effect; done still pulses.
- Reset mid-operation: immediate IDLE, all outputs 0.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> busy cycles 1-34; done in cycle 35; quotient=14, remainder=2, div_by_zero=0; stall_req high cycles 0-34.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Divide by zero: unsigned 5 / 0 -> done in cycle 2, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following 9 / 3 gives quotient=3, remainder=0, div_by_zero=0.
- Cancel asserted in cycle 10 of 100 / 7 -> busy=0 in cycle 11, no done, quotient/remainder unchanged. A new 20 / 6 started in cycle 12 -> done in cycle 47, quotient=3, remainder=2.
- start pulsed in cycles 5 and 34 while busy -> ignored; exactly one done. start and cancel together in IDLE -> stays IDLE, stall_req=0.
- rst_n low during ITER -> all outputs 0 immediately. After release, 0xFFFFFFFF / 1 unsigned -> quotient=0xFFFFFFFF, remainder=0.
